mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-outstanding arbiter that shares one 64-bit backing memory port between the instruction-fetch stage and the data (load/store) stage of the 5-stage RISC-V pipeline. Data requests get priority, with a streak limit so fetch never starves. The arbiter sequences each transaction through a fixed memory read latency, returns the response to the owning requester, and drops fetch responses killed by a taken branch. It replaces the separate instruction and data caches with one shared memory.

## Interface
Parameters:
- ADDR_W, 32: word-address width, shared by both requesters and the memory.
- LAT, 2: memory read latency in cycles, LAT ≥ 1.
- STREAK_MAX, 4: maximum consecutive data grants while fetch is waiting, ≥ 1.

Ports (reset rst, asynchronous, active-low; clock clk):
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- if_req_i  in  1  fetch request; held until granted
- if_addr_i  in  ADDR_W  fetch word address
- if_kill_i  in  1  discard any in-flight fetch response (branch redirect)
- if_gnt_o  out  1  fetch request accepted this cycle
- if_rvalid_o  out  1  fetch response valid
- if_rdata_o  out  32  instruction, mem_rdata_i[31:0]
- d_req_i  in  1  data request; held until granted
- d_we_i  in  1  1 = store, 0 = load
- d_addr_i  in  ADDR_W  data word address
- d_wdata_i  in  64  store data
- d_gnt_o  out  1  data request accepted this cycle
- d_rvalid_o  out  1  load data or store acknowledge valid
- d_rdata_o  out  64  load data; 0 for a store acknowledge
- mem_req_o  out  1  memory access strobe
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  64  memory write data
- mem_rdata_i  in  64  memory read data, valid LAT cycles after mem_req_o
- busy_o  out  1  transaction in flight

## Operation
- FSM states:
  - IDLE: no transaction in flight.
  - WAIT: one transaction in flight. Latency counter cnt, owner (IF/D) and the store flag are registered.
- Grant is possible in IDLE, or in WAIT when cnt==0. The grant is combinational in that cycle.
  - Asserts exactly one of if_gnt_o / d_gnt_o.
  - mem_req_o=1, with mem_we_o, mem_addr_o and mem_wdata_o driven straight from the winner's inputs.
  - mem_we_o=0 for fetch.
- On grant: state→WAIT, cnt←LAT-1, owner and store flag latched. Otherwise, in WAIT with cnt==0, state→IDLE.
- In WAIT with cnt≠0: cnt decrements, and no grant is given.
- Response, in WAIT with cnt==0:
  - If owner=IF: if_rvalid_o=1, unless killed.
  - If owner=D: d_rvalid_o=1, and d_rdata_o = mem_rdata_i for a load or 0 for a store.
  - rdata outputs are 0 whenever the matching rvalid is 0.
- Arbitration:
  - Fetch only → fetch wins. Data only → data wins.
  - Both requesting → data wins unless streak==STREAK_MAX, in which case fetch wins.
- streak counter:
  - Increments on a data grant while if_req_i=1.
  - Clears on a data grant while if_req_i=0.
  - Clears on any fetch grant.
  - Saturates at STREAK_MAX.
- Kill:
  - if_kill_i while an IF-owned transaction is in WAIT sets a kill flag. The response is suppressed (if_rvalid_o=0) and the flag clears at cnt==0.
  - if_kill_i in the response cycle itself also suppresses the response.
  - if_kill_i in the fetch grant cycle suppresses that new transaction's response.
  - if_kill_i has no effect on data transactions or in IDLE.
- busy_o=1 in WAIT.

## Timing
- Grant at cycle T → response at T+LAT. The next grant may occur at T+LAT, so throughput is 1 transaction per LAT cycles. With LAT=1 a grant can occur every cycle.
- Stores: memory is written at the edge ending grant cycle T; the acknowledge arrives at T+LAT.
- Reset values: state IDLE, cnt 0, streak 0, kill flag 0. All outputs are 0 during and after reset.
- Reset mid-transaction aborts it; no rvalid is ever produced for it.
- Requester dropping req before grant is legal and is treated as no request.

## Structure
- Package mem_arb_pkg holds:
  - state_t {IDLE, WAIT}
  - owner_t {OWN_IF, OWN_D}
  - the counter width $clog2(LAT+1) and the streak width $clog2(STREAK_MAX+1)
- Sub-module mem_arb_pick holds the combinational winner selection plus the streak counter register. The top holds the FSM, cnt, the owner and kill flags, and response routing.

## Test plan
- Fetch only, LAT=2, if_addr_i=0x10 with mem returning 0x00500093 → if_gnt_o at T, if_rvalid_o=1 with if_rdata_o=0x00500093 at T+2, no other rvalid.
- Simultaneous if_req_i and d_req_i (load from 0x20, mem 0xDEADBEEF) → d_gnt_o first. Fetch granted at T+2, d_rvalid_o at T+2, if_rvalid_o at T+4.
- d_req_i held high continuously with if_req_i high, STREAK_MAX=4 → grant sequence D,D,D,D,IF,D,…; streak returns to 0 after the IF grant.
- Fetch granted, if_kill_i pulsed at T+1 → if_rvalid_o stays 0 at T+2. A following data grant at T+2 returns normally.
- Store d_we_i=1, d_addr_i=0x8, d_wdata_i=0x1234 → mem_we_o=1 and mem_wdata_o=0x1234 at T. Acknowledge d_rvalid_o=1 with d_rdata_o=0 at T+LAT. A subsequent load of 0x8 returns 0x1234.
- rst low at T+1 during an in-flight load → all outputs 0 immediately. After release, state is IDLE, no stale d_rvalid_o, and the next request is granted in its first cycle.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and width helpers for the fetch/data memory arbiter.
package mem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  // Width of the latency countdown for a given memory latency.
  function automatic int unsigned cnt_width(input int unsigned lat);
    return $clog2(lat + 1);
  endfunction

  // Width of the data-grant streak counter for a given streak limit.
  function automatic int unsigned streak_width(input int unsigned smax);
    return $clog2(smax + 1);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between fetch and data, with the data-streak limiter.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int unsigned STREAK_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic if_req_i,
  input  logic d_req_i,
  output logic if_win_c,
  output logic d_win_c
);

  localparam int unsigned SW = streak_width(STREAK_MAX);
  localparam logic [SW-1:0] SMAX = SW'(STREAK_MAX);

  logic [SW-1:0] streak_q, streak_d;
  logic          limit_hit;

  assign limit_hit = (streak_q == SMAX);

  // Data wins ties unless fetch has waited through a full streak.
  always_comb begin
    if_win_c = 1'b0;
    d_win_c  = 1'b0;
    if (en_i) begin
      if (d_req_i && !(if_req_i && limit_hit)) begin
        d_win_c = 1'b1;
      end else if (if_req_i) begin
        if_win_c = 1'b1;
      end
    end
  end

  // Streak counts data grants made while fetch was waiting.
  always_comb begin
    streak_d = streak_q;
    if (if_win_c) begin
      streak_d = '0;
    end else if (d_win_c) begin
      if (!if_req_i) begin
        streak_d = '0;
      end else if (!limit_hit) begin
        streak_d = streak_q + SW'(1);
      end
    end
  end

  // Streak register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch and data.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned LAT        = 2,
  parameter int unsigned STREAK_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_kill_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [31:0]       if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [63:0]       d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [63:0]       d_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [63:0]       mem_wdata_o,
  input  logic [63:0]       mem_rdata_i,
  output logic              busy_o
);

  localparam int unsigned CNT_W = cnt_width(LAT);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);

  state_t           state_q, state_d;
  owner_t           owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             store_q, store_d;
  logic             kill_q, kill_d;

  logic grant_ok, resp_cycle, if_win, d_win;

  // Grant window; gated by rst so nothing is granted while reset is held.
  assign grant_ok   = rst && ((state_q == IDLE) || (cnt_q == '0));
  assign resp_cycle = (state_q == WAIT) && (cnt_q == '0);

  mem_arb_pick #(
    .STREAK_MAX (STREAK_MAX)
  ) u_pick (
    .clk      (clk),
    .rst      (rst),
    .en_i     (grant_ok),
    .if_req_i (if_req_i),
    .d_req_i  (d_req_i),
    .if_win_c (if_win),
    .d_win_c  (d_win)
  );

  // Next-state logic and combinational memory-port / response routing.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    store_d     = store_q;
    kill_d      = kill_q;
    if_gnt_o    = if_win;
    d_gnt_o     = d_win;
    mem_req_o   = if_win | d_win;
    mem_we_o    = d_win & d_we_i;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if_rvalid_o = 1'b0;
    if_rdata_o  = '0;
    d_rvalid_o  = 1'b0;
    d_rdata_o   = '0;
    busy_o      = (state_q == WAIT);

    if (d_win) begin
      mem_addr_o  = d_addr_i;
      mem_wdata_o = d_wdata_i;
    end else if (if_win) begin
      mem_addr_o  = if_addr_i;
    end

    if (resp_cycle) begin
      if (owner_q == OWN_IF) begin
        if (!kill_q && !if_kill_i) begin
          if_rvalid_o = 1'b1;
          if_rdata_o  = mem_rdata_i[31:0];
        end
      end else begin
        d_rvalid_o = 1'b1;
        d_rdata_o  = store_q ? 64'd0 : mem_rdata_i;
      end
    end

    case (state_q)
      IDLE: ;
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          kill_d  = 1'b0;
        end else begin
          cnt_d  = cnt_q - CNT_W'(1);
          kill_d = kill_q | ((owner_q == OWN_IF) & if_kill_i);
        end
      end
      default: state_d = IDLE;
    endcase

    if (if_win || d_win) begin
      state_d = WAIT;
      cnt_d   = CNT_LOAD;
      owner_d = d_win ? OWN_D : OWN_IF;
      store_d = d_win & d_we_i;
      kill_d  = if_win & if_kill_i;
    end
  end

  // FSM and transaction bookkeeping registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= OWN_IF;
      cnt_q   <= '0;
      store_q <= 1'b0;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      store_q <= store_d;
      kill_q  <= kill_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed stimulus, decoupled response monitor.
module tb_mem_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LAT    = 2;
  localparam int unsigned SMAX   = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req_i, if_kill_i, d_req_i, d_we_i;
  logic [ADDR_W-1:0] if_addr_i, d_addr_i;
  logic [63:0]       d_wdata_i, mem_rdata_i;
  logic              if_gnt_o, if_rvalid_o, d_gnt_o, d_rvalid_o;
  logic              mem_req_o, mem_we_o, busy_o;
  logic [31:0]       if_rdata_o;
  logic [63:0]       d_rdata_o, mem_wdata_o;
  logic [ADDR_W-1:0] mem_addr_o;

  typedef struct {
    bit          is_if;
    logic [63:0] data;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  logic [63:0] mem [0:255];
  logic [63:0] pipe [0:LAT-1];

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W     (ADDR_W),
    .LAT        (LAT),
    .STREAK_MAX (SMAX)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_kill_i   (if_kill_i),
    .if_gnt_o    (if_gnt_o),
    .if_rvalid_o (if_rvalid_o),
    .if_rdata_o  (if_rdata_o),
    .d_req_i     (d_req_i),
    .d_we_i      (d_we_i),
    .d_addr_i    (d_addr_i),
    .d_wdata_i   (d_wdata_i),
    .d_gnt_o     (d_gnt_o),
    .d_rvalid_o  (d_rvalid_o),
    .d_rdata_o   (d_rdata_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .busy_o      (busy_o)
  );

  // Backing memory with fixed read latency; preloaded while reset is low.
  always @(posedge clk) begin
    if (!rst) begin
      mem[8'h10] <= 64'h0000_0000_0050_0093;
      mem[8'h20] <= 64'h0000_0000_DEAD_BEEF;
    end else if (mem_req_o && mem_we_o) begin
      mem[mem_addr_o[7:0]] <= mem_wdata_o;
    end
    pipe[0] <= mem[mem_addr_o[7:0]];
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata_i = pipe[LAT-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input bit is_if, input logic [63:0] data);
    exp_t e;
    e.is_if = is_if;
    e.data  = data;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    repeat (n) step();
  endtask

  // Response monitor: pops the scoreboard whenever a response is presented.
  always @(negedge clk) begin
    if (rst) begin
      logic [63:0] idle_bits;
      idle_bits = (if_rvalid_o ? 64'd0 : {32'd0, if_rdata_o}) | (d_rvalid_o ? 64'd0 : d_rdata_o);
      chk("rdata_zero_when_invalid", idle_bits, 64'd0);
      if (if_rvalid_o || d_rvalid_o) begin
        if (q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_rvalid actual if=%b d=%b required none at %0t",
                   if_rvalid_o, d_rvalid_o, $time);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("resp_owner", {62'd0, if_rvalid_o, d_rvalid_o}, e.is_if ? 64'd2 : 64'd1);
          chk("resp_data", e.is_if ? {32'd0, if_rdata_o} : d_rdata_o, e.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    logic exp_d [7];
    exp_d = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    rst = 1'b0; if_req_i = 1'b1; if_kill_i = 1'b0; d_req_i = 1'b0; d_we_i = 1'b0;
    if_addr_i = '0; d_addr_i = '0; d_wdata_i = '0;

    // Reset: outputs quiet even with a request pending.
    @(negedge clk);
    @(negedge clk);
    chk("reset_outputs", 64'(|{if_gnt_o, if_rvalid_o, if_rdata_o, d_gnt_o, d_rvalid_o, d_rdata_o,
                             mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, busy_o}), 64'd0);
    step(); rst = 1'b1; if_req_i = 1'b0;

    // Fetch only.
    step(); if_req_i = 1'b1; if_addr_i = 32'h10;
    @(negedge clk);
    chk("t1_if_gnt", 64'(if_gnt_o), 64'd1);
    chk("t1_d_gnt", 64'(d_gnt_o), 64'd0);
    chk("t1_mem_req", 64'(mem_req_o), 64'd1);
    chk("t1_mem_we", 64'(mem_we_o), 64'd0);
    chk("t1_mem_addr", 64'(mem_addr_o), 64'h10);
    push(1'b1, 64'h0050_0093);
    step(); if_req_i = 1'b0;
    @(negedge clk);
    chk("t1_busy", 64'(busy_o), 64'd1);
    chk("t1_no_gnt_mid", 64'(if_gnt_o | d_gnt_o), 64'd0);
    step();
    @(negedge clk);
    chk("t1_if_rvalid", 64'(if_rvalid_o), 64'd1);
    drain(3);

    // Simultaneous requests: data first, fetch at T+2.
    step(); if_req_i = 1'b1; if_addr_i = 32'h10; d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h20;
    @(negedge clk);
    chk("t2_d_gnt", 64'(d_gnt_o), 64'd1);
    chk("t2_if_gnt_lost", 64'(if_gnt_o), 64'd0);
    push(1'b0, 64'h0000_0000_DEAD_BEEF);
    step(); d_req_i = 1'b0;
    @(negedge clk);
    chk("t2_if_wait", 64'(if_gnt_o), 64'd0);
    step();
    @(negedge clk);
    chk("t2_if_gnt", 64'(if_gnt_o), 64'd1);
    chk("t2_d_rvalid", 64'(d_rvalid_o), 64'd1);
    push(1'b1, 64'h0050_0093);
    step(); if_req_i = 1'b0;
    drain(4);

    // Streak limit: D,D,D,D,IF,D,D with both requesting continuously.
    step(); if_req_i = 1'b1; d_req_i = 1'b1; d_addr_i = 32'h20; if_addr_i = 32'h10;
    for (int g = 0; g < 7; g++) begin
      int waited;
      waited = 0;
      @(negedge clk);
      while (!(if_gnt_o || d_gnt_o) && waited < 8) begin
        @(negedge clk);
        waited++;
      end
      chk("streak_grant", {62'd0, if_gnt_o, d_gnt_o}, exp_d[g] ? 64'd1 : 64'd2);
      if (d_gnt_o) push(1'b0, 64'h0000_0000_DEAD_BEEF);
      else if (if_gnt_o) push(1'b1, 64'h0050_0093);
    end
    step(); if_req_i = 1'b0; d_req_i = 1'b0;
    drain(4);

    // Kill mid-flight, then a data grant in the would-be response cycle.
    step(); if_req_i = 1'b1; if_addr_i = 32'h10;
    @(negedge clk);
    chk("t4_if_gnt", 64'(if_gnt_o), 64'd1);
    step(); if_req_i = 1'b0; if_kill_i = 1'b1;
    step(); if_kill_i = 1'b0; d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h20;
    @(negedge clk);
    chk("t4_killed_rvalid", 64'(if_rvalid_o), 64'd0);
    chk("t4_d_gnt", 64'(d_gnt_o), 64'd1);
    push(1'b0, 64'h0000_0000_DEAD_BEEF);
    step(); d_req_i = 1'b0;
    drain(3);

    // Kill in the grant cycle.
    step(); if_req_i = 1'b1; if_kill_i = 1'b1;
    @(negedge clk);
    chk("t4b_if_gnt", 64'(if_gnt_o), 64'd1);
    step(); if_req_i = 1'b0; if_kill_i = 1'b0;
    step();
    @(negedge clk);
    chk("t4b_killed_rvalid", 64'(if_rvalid_o), 64'd0);
    drain(3);

    // Kill in the response cycle.
    step(); if_req_i = 1'b1;
    @(negedge clk);
    chk("t4c_if_gnt", 64'(if_gnt_o), 64'd1);
    step(); if_req_i = 1'b0;
    step(); if_kill_i = 1'b1;
    @(negedge clk);
    chk("t4c_killed_rvalid", 64'(if_rvalid_o), 64'd0);
    step(); if_kill_i = 1'b0;
    drain(3);

    // Kill has no effect on a data transaction.
    step(); d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h20; if_kill_i = 1'b1;
    @(negedge clk);
    chk("t4d_d_gnt", 64'(d_gnt_o), 64'd1);
    push(1'b0, 64'h0000_0000_DEAD_BEEF);
    step(); d_req_i = 1'b0;
    step();
    @(negedge clk);
    chk("t4d_d_rvalid", 64'(d_rvalid_o), 64'd1);
    step(); if_kill_i = 1'b0;
    drain(3);

    // Store, acknowledge, then read back.
    step(); d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h8; d_wdata_i = 64'h1234;
    @(negedge clk);
    chk("t5_d_gnt", 64'(d_gnt_o), 64'd1);
    chk("t5_mem_we", 64'(mem_we_o), 64'd1);
    chk("t5_mem_addr", 64'(mem_addr_o), 64'h8);
    chk("t5_mem_wdata", mem_wdata_o, 64'h1234);
    push(1'b0, 64'd0);
    step(); d_req_i = 1'b0; d_we_i = 1'b0; d_wdata_i = '0;
    step(); d_req_i = 1'b1; d_addr_i = 32'h8;
    @(negedge clk);
    chk("t5_load_gnt", 64'(d_gnt_o), 64'd1);
    chk("t5_ack_rvalid", 64'(d_rvalid_o), 64'd1);
    push(1'b0, 64'h1234);
    step(); d_req_i = 1'b0;
    drain(4);

    // Reset during an in-flight load.
    step(); d_req_i = 1'b1; d_addr_i = 32'h20;
    @(negedge clk);
    chk("t6_d_gnt", 64'(d_gnt_o), 64'd1);
    step(); d_req_i = 1'b0; if_req_i = 1'b1; rst = 1'b0;
    @(negedge clk);
    chk("t6_reset_outputs", 64'(|{if_gnt_o, if_rvalid_o, if_rdata_o, d_gnt_o, d_rvalid_o, d_rdata_o,
                                mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, busy_o}), 64'd0);
    step(); rst = 1'b1; if_req_i = 1'b0; d_req_i = 1'b1; d_addr_i = 32'h20;
    @(negedge clk);
    chk("t6_first_gnt", 64'(d_gnt_o), 64'd1);
    chk("t6_no_stale_rvalid", 64'(d_rvalid_o), 64'd0);
    push(1'b0, 64'h0000_0000_DEAD_BEEF);
    step(); d_req_i = 1'b0;
    drain(4);

    chk("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
